// File: rtl/data_types_pkg.sv
// rtl/data_types_pkg.sv - shared UART types, configuration layout and oversampling constants
package data_types_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  typedef struct packed {
    logic [7:0] br_div;
    logic       word;
    logic       stop;
    logic       en;
  } tx_config_t;

  typedef tx_config_t rx_config_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead receive FIFO; owns overrun and same-cycle push/pop rules
module uart_rx_fifo
  import data_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  byte_t din,
  output byte_t dout,
  output logic  empty,
  output logic  full,
  output logic  overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  byte_t       mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        overrun_q, overrun_d;
  logic        do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign overrun = overrun_q;

  always_comb begin
    wr_d      = do_push ? wr_q + PTR_ONE : wr_q;
    rd_d      = do_pop ? rd_q + PTR_ONE : rd_q;
    overrun_d = push && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: synchroniser, 16x prescaler, frame FSM and receive FIFO
// Optional 2-of-3 majority bit sampling with UART_RX_MAJORITY_EN.
module uart_rx
  import data_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  rx_config_t cfg,
  input  logic       rd_en,
  output byte_t      rd_data,
  output logic       rxe,
  output logic       rxf,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, rx_s;
  logic [7:0]  presc_q, presc_d;
  logic [3:0]  tick_q, tick_d;
  logic [2:0]  bit_q, bit_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic        stop_ok_q, stop_ok_d;
  byte_t       shift_q, shift_d;
  logic [7:0]  br_div_q, br_div_d;
  logic        word_q, word_d;
  logic        stop_q, stop_d;
  logic        frame_err_q, frame_err_d;
  logic        tick, sample, bit_val, push;
  byte_t       push_data;

  assign rx_s = sync2_q;
  assign tick = (presc_q == br_div_q);

  // the tick counter runs freely across the frame, so every decision lands 16 ticks apart
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] DECIDE_TICK = 4'(MID_TICK + 2);
  logic vote7_q, vote8_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vote7_q <= 1'b1;
      vote8_q <= 1'b1;
    end else if (tick && tick_q == 4'(MID_TICK)) begin
      vote7_q <= rx_s;
    end else if (tick && tick_q == 4'(MID_TICK + 1)) begin
      vote8_q <= rx_s;
    end
  end

  assign bit_val = maj3(vote7_q, vote8_q, rx_s);
`else
  localparam logic [3:0] DECIDE_TICK = 4'(MID_TICK);
  assign bit_val = rx_s;
`endif

  assign sample = tick && (tick_q == DECIDE_TICK);
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    stop_cnt_d  = stop_cnt_q;
    stop_ok_d   = stop_ok_q;
    shift_d     = shift_q;
    br_div_d    = br_div_q;
    word_d      = word_q;
    stop_d      = stop_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    push_data   = word_q ? shift_q : {1'b0, shift_q[7:1]};

    if (state_q != IDLE) begin
      if (tick) begin
        presc_d = '0;
        tick_d  = tick_q + 4'd1;
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (cfg.en && !rx_s) begin
          state_d    = START;
          presc_d    = '0;
          tick_d     = '0;
          bit_d      = '0;
          stop_cnt_d = 1'b0;
          stop_ok_d  = 1'b1;
          br_div_d   = cfg.br_div;
          word_d     = cfg.word;
          stop_d     = cfg.stop;
        end
      end
      START: begin
        if (sample) state_d = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          shift_d = {bit_val, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == (word_q ? 3'd7 : 3'd6)) state_d = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          stop_cnt_d = 1'b1;
          stop_ok_d  = stop_ok_q & bit_val;
          if (stop_cnt_q == stop_q) begin
            state_d = IDLE;
            if (stop_ok_q && bit_val) push = 1'b1;
            else frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!cfg.en) begin
      state_d     = IDLE;
      push        = 1'b0;
      frame_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      presc_q     <= '0;
      tick_q      <= '0;
      bit_q       <= '0;
      stop_cnt_q  <= 1'b0;
      stop_ok_q   <= 1'b0;
      shift_q     <= '0;
      br_div_q    <= '0;
      word_q      <= 1'b0;
      stop_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      stop_cnt_q  <= stop_cnt_d;
      stop_ok_q   <= stop_ok_d;
      shift_q     <= shift_d;
      br_div_q    <= br_div_d;
      word_q      <= word_d;
      stop_q      <= stop_d;
      frame_err_q <= frame_err_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (rd_en),
    .din    (push_data),
    .dout   (rd_data),
    .empty  (rxe),
    .full   (rxf),
    .overrun(overrun)
  );

endmodule
